// File: rtl/adder_serial_nb_pkg.sv
// Shared types and helpers for the serial (chunked) ripple-carry adder/subtractor.
package adder_serial_nb_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_CHUNK = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // One-bit full-adder cell; returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic ci);
    return {(a & b) | (ci & (a ^ b)), a ^ b ^ ci};
  endfunction

endpackage

// File: rtl/adder_serial_nb_if.sv
// Request/result bus of the serial adder: operands in, START/BUSY/DONE handshake, result out.
interface adder_serial_nb_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, s, cout, ovf
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, s, cout, ovf
  );
endinterface

// File: rtl/adder_serial_nb_chunk.sv
// Combinational CHUNK-bit ripple-carry adder built from full-adder cells.
module adder_serial_nb_chunk
  import adder_serial_nb_pkg::*;
#(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [CHUNK:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    logic [1:0] r;
    assign r      = full_add(a[i], b[i], c[i]);
    assign s[i]   = r[0];
    assign c[i+1] = r[1];
  end

  assign co    = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/adder_serial_nb.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per clock through a shared chunk adder,
// carry held between slices, START/BUSY/DONE handshake.
module adder_serial_nb
  import adder_serial_nb_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CHUNK = DEF_CHUNK
) (
  input logic              clk,
  input logic              rst_n,
  adder_serial_nb_if.slave bus
);

  localparam int unsigned NCHUNK = (CHUNK == 0) ? 1 : WIDTH / CHUNK;
  localparam int unsigned KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned TOP    = WIDTH - CHUNK;

  if (WIDTH < 2 || CHUNK == 0 || (WIDTH % CHUNK) != 0) begin : g_param_check
    $error("adder_serial_nb: WIDTH must be >= 2 and a multiple of CHUNK");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [KW-1:0]    k_q, k_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [CHUNK-1:0] sum;
  logic             co;
  logic             c_msb;

  // Operands shift right each RUN cycle, so the active slice is always the low CHUNK bits.
  adder_serial_nb_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a     (a_q[CHUNK-1:0]),
    .b     (b_q[CHUNK-1:0]),
    .ci    (carry_q),
    .s     (sum),
    .co    (co),
    .c_msb (c_msb)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    s_d     = s_q;
    k_d     = k_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ? ~bus.cin : bus.cin;
          k_d     = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        carry_d = co;
        k_d     = KW'(k_q + 1'b1);
        // Slice sums enter at the MSB end; after NCHUNK shifts slice 0 sits at the LSBs.
        acc_d   = (acc_q >> CHUNK) | (WIDTH'(sum) << TOP);
        if (k_q == KW'(NCHUNK - 1)) begin
          s_d     = acc_d;
          cout_d  = co;
          // Carry into and out of the MSB differ exactly when the operand signs agree
          // and the result sign does not.
          ovf_d   = co ^ c_msb;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy_d = (state_d == ST_RUN);
  assign done_d = (state_d == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      s_q     <= '0;
      k_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      s_q     <= s_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.s    = s_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_adder_serial_nb.sv
// Self-checking bench for adder_serial_nb: directed table, handshake corners, sweeps and random ops
// on 16/4, 10/5 and 8/8 configurations.
module tb_adder_serial_nb;

  typedef struct {
    logic [15:0] s;
    logic        cout;
    logic        ovf;
  } res_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        cout;
    logic        ovf;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  adder_serial_nb_if #(.WIDTH(16)) if16 ();
  adder_serial_nb_if #(.WIDTH(10)) if10 ();
  adder_serial_nb_if #(.WIDTH(8))  if8 ();

  adder_serial_nb #(.WIDTH(16), .CHUNK(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));
  adder_serial_nb #(.WIDTH(10), .CHUNK(5)) dut10 (.clk(clk), .rst_n(rst_n), .bus(if10));
  adder_serial_nb #(.WIDTH(8),  .CHUNK(8)) dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference: plain integer arithmetic on the mathematical values.
  function automatic res_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic sub);
    res_t   r;
    longint full = 64'sd1 << w;
    longint half = 64'sd1 << (w - 1);
    longint ua   = longint'(a) % full;
    longint ub   = longint'(b) % full;
    longint c    = cin ? 64'sd1 : 64'sd0;
    longint sa   = (ua >= half) ? ua - full : ua;
    longint sb   = (ub >= half) ? ub - full : ub;
    longint t, sr;
    if (!sub) begin
      t      = ua + ub + c;
      sr     = sa + sb + c;
      r.cout = (t >= full);
    end else begin
      t      = ua - ub - c;
      sr     = sa - sb - c;
      r.cout = (t >= 0);
    end
    r.s   = 16'((t % full + full) % full);
    r.ovf = (sr >= half) || (sr < -half);
    return r;
  endfunction

  function automatic int kof(input int w);
    return (w == 0) ? 4 : (w == 1) ? 2 : 1;
  endfunction

  task automatic drive(input int w, input logic st, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic sub);
    case (w)
      0: begin if16.start = st; if16.a = a;      if16.b = b;      if16.cin = cin; if16.sub = sub; end
      1: begin if10.start = st; if10.a = 10'(a); if10.b = 10'(b); if10.cin = cin; if10.sub = sub; end
      default: begin if8.start = st; if8.a = 8'(a); if8.b = 8'(b); if8.cin = cin; if8.sub = sub; end
    endcase
  endtask

  task automatic peek(input int w, output logic busy, output logic done, output res_t r);
    case (w)
      0: begin busy = if16.busy; done = if16.done; r.s = if16.s;      r.cout = if16.cout; r.ovf = if16.ovf; end
      1: begin busy = if10.busy; done = if10.done; r.s = 16'(if10.s); r.cout = if10.cout; r.ovf = if10.ovf; end
      default: begin busy = if8.busy; done = if8.done; r.s = 16'(if8.s); r.cout = if8.cout; r.ovf = if8.ovf; end
    endcase
  endtask

  task automatic scramble(input int w, input logic st);
    drive(w, st, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
  endtask

  // Waits (bounded) for DONE; lat counts clock edges since the accepting edge.
  task automatic wait_done(input int w, inout int lat, output int busy_n, output bit held,
                           input res_t prev, output res_t r);
    logic bz, dn;
    busy_n = 0;
    held   = 1'b1;
    peek(w, bz, dn, r);
    while (!dn && lat < 20) begin
      if (bz) busy_n++;
      if (r != prev) held = 1'b0;
      @(negedge clk);
      lat++;
      peek(w, bz, dn, r);
    end
  endtask

  task automatic run_op(input int w, input string nm, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sub, input res_t exp);
    logic bz, dn;
    res_t prev, r;
    int   lat, busy_n;
    bit   held;
    @(negedge clk);
    peek(w, bz, dn, prev);
    drive(w, 1'b1, a, b, cin, sub);
    @(posedge clk);
    @(negedge clk);
    scramble(w, 1'b0);
    lat = 0;
    wait_done(w, lat, busy_n, held, prev, r);
    chk({nm, ".lat"},  32'(lat), 32'(kof(w)));
    chk({nm, ".busy"}, 32'(busy_n), 32'(kof(w)));
    chk({nm, ".hold"}, 32'(held), 32'd1);
    chk({nm, ".s"},    32'(r.s), 32'(exp.s));
    chk({nm, ".cout"}, 32'(r.cout), 32'(exp.cout));
    chk({nm, ".ovf"},  32'(r.ovf), 32'(exp.ovf));
  endtask

  initial begin
    vec_t        tbl[9];
    logic        bz, dn;
    res_t        r, e, prev;
    int          lat, busy_n, act;
    bit          held;
    logic [15:0] a, b;
    logic        cin, sub;

    n_pass  = 0;
    n_total = 0;
    tbl[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0};
    tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tbl[4] = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0};
    tbl[5] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    tbl[6] = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[7] = '{16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0};
    tbl[8] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};

    // Reset held with START asserted: everything stays at zero.
    rst_n = 1'b0;
    for (int w = 0; w < 3; w++) scramble(w, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      peek(0, bz, dn, r);
      chk("reset_hold", {bz, dn, r.s, r.cout, r.ovf}, 32'd0);
    end
    for (int w = 0; w < 3; w++) scramble(w, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      peek(0, bz, dn, r);
      chk("post_reset", {bz, dn, r.s, r.cout, r.ovf}, 32'd0);
    end

    // Directed vectors.
    for (int i = 0; i < 9; i++) begin
      e = '{tbl[i].s, tbl[i].cout, tbl[i].ovf};
      run_op(0, $sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, e);
    end

    // START pulsed mid-RUN is ignored.
    @(negedge clk);
    peek(0, bz, dn, prev);
    drive(0, 1'b1, 16'h0003, 16'h0004, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    scramble(0, 1'b0);
    @(negedge clk);
    drive(0, 1'b1, 16'hAAAA, 16'h5555, 1'b1, 1'b1);
    @(negedge clk);
    scramble(0, 1'b0);
    lat = 2;
    wait_done(0, lat, busy_n, held, prev, r);
    chk("midstart.lat", 32'(lat), 32'd4);
    chk("midstart.s", 32'(r.s), 32'h0007);
    @(negedge clk);
    peek(0, bz, dn, r);
    chk("midstart.idle", {30'd0, bz, dn}, 32'd0);

    // START held through DONE: back-to-back with no idle cycle.
    @(negedge clk);
    peek(0, bz, dn, prev);
    drive(0, 1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b1, 16'h0F0F, 16'h0101, 1'b0, 1'b1);
    lat = 0;
    wait_done(0, lat, busy_n, held, prev, r);
    chk("b2b.lat1", 32'(lat), 32'd4);
    chk("b2b.s1", 32'(r.s), 32'h3333);
    prev = r;
    @(negedge clk);
    scramble(0, 1'b0);
    peek(0, bz, dn, r);
    chk("b2b.nobubble", 32'(bz), 32'd1);
    lat = 1;
    wait_done(0, lat, busy_n, held, prev, r);
    chk("b2b.gap", 32'(lat), 32'd5);
    chk("b2b.hold", 32'(held), 32'd1);
    chk("b2b.s2", {15'd0, r.cout, r.s}, {15'd0, 1'b1, 16'h0E0E});

    // Reset mid-RUN: immediate clear, no DONE afterwards.
    @(negedge clk);
    drive(0, 1'b1, 16'h1234, 16'h1111, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    scramble(0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    peek(0, bz, dn, r);
    chk("midreset.clear", {bz, dn, r.s, r.cout, r.ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    act = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      peek(0, bz, dn, r);
      if (bz || dn) act++;
    end
    chk("midreset.nodone", 32'(act), 32'd0);

    // 10-bit sweep: A+=2, B+=1, CIN toggling.
    a = 16'h03E0;
    b = 16'h01F0;
    cin = 1'b0;
    for (int i = 0; i < 32; i++) begin
      run_op(1, $sformatf("sweep%0d", i), a, b, cin, 1'b0, model(10, a, b, cin, 1'b0));
      a = (a + 16'd2) & 16'h03FF;
      b = (b + 16'd1) & 16'h03FF;
      cin = ~cin;
    end

    // Random operations on every configuration.
    for (int i = 0; i < 30; i++) begin
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      run_op(0, $sformatf("rnd16_%0d", i), a, b, cin, sub, model(16, a, b, cin, sub));
    end
    for (int i = 0; i < 12; i++) begin
      a = 16'($urandom) & 16'h03FF; b = 16'($urandom) & 16'h03FF; cin = 1'($urandom); sub = 1'($urandom);
      run_op(1, $sformatf("rnd10_%0d", i), a, b, cin, sub, model(10, a, b, cin, sub));
    end
    for (int i = 0; i < 12; i++) begin
      a = 16'($urandom) & 16'h00FF; b = 16'($urandom) & 16'h00FF; cin = 1'($urandom); sub = 1'($urandom);
      run_op(2, $sformatf("rnd8_%0d", i), a, b, cin, sub, model(8, a, b, cin, sub));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
